// File: rtl/bb_control_sequencer_pkg.sv
// Shared definitions for the bb_core control sequencer: unit indices, opcodes,
// sequencer states and the decoded-instruction record.
package bb_control_sequencer_pkg;

  localparam logic [3:0] INDEX_EN_RSVD_LO    = 4'd0;
  localparam logic [3:0] INDEX_EN_IR         = 4'd1;
  localparam logic [3:0] INDEX_EN_PC         = 4'd2;
  localparam logic [3:0] INDEX_EN_CR         = 4'd6;
  localparam logic [3:0] INDEX_EN_SKIN_FETCH = 4'd12;
  localparam logic [3:0] INDEX_EN_SKIN_DATA  = 4'd13;
  localparam logic [3:0] INDEX_EN_SKIN_IO    = 4'd14;
  localparam logic [3:0] INDEX_EN_RSVD_HI    = 4'd15;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_LOAD_IR   = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_SKIN_WAIT = 3'd4,
    ST_XFER      = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  typedef struct packed {
    logic [3:0] dst;
    logic [3:0] src;
    logic       skin_rd;
    logic       skin_wr;
    logic       illegal;
    logic       nop;
    logic       halt;
    logic       jump;
  } decode_t;

  function automatic logic [15:0] unit_onehot(input logic [3:0] idx);
    unit_onehot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/bb_control_sequencer_if.sv
// Sequencer-side bundle: instruction/condition inputs, skin handshake and the
// register-file unit enable buses.
interface bb_control_sequencer_if #(parameter int DATA_WIDTH = 8);

  logic [DATA_WIDTH-1:0] i_instruction;
  logic                  i_cond;
  logic                  i_stall;
  logic                  i_skin_ack;
  logic                  o_skin_req;
  logic                  o_skin_we;
  logic [15:0]           o_unit_ien;
  logic [15:0]           o_unit_oen;
  logic                  o_illegal;
  logic                  o_bus_error;
  logic                  o_halted;

  modport slave (
    input  i_instruction, i_cond, i_stall, i_skin_ack,
    output o_skin_req, o_skin_we, o_unit_ien, o_unit_oen, o_illegal, o_bus_error, o_halted
  );

  modport master (
    output i_instruction, i_cond, i_stall, i_skin_ack,
    input  o_skin_req, o_skin_we, o_unit_ien, o_unit_oen, o_illegal, o_bus_error, o_halted
  );

endinterface

// File: rtl/bb_control_sequencer_decode.sv
// Combinational instruction decoder: splits the opcode into dst/src unit indices
// and classifies it (NOP, HALT, conditional jump, skin read/write, illegal).
module bb_instr_decode
  import bb_control_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_instruction,
  output decode_t               o_dec
);

  logic [3:0] dst_s;
  logic [3:0] src_s;
  logic       nop_s;
  logic       halt_s;
  logic       rsvd_s;
  logic       clash_s;

  assign dst_s  = i_instruction[7:4];
  assign src_s  = i_instruction[3:0];
  assign nop_s  = (i_instruction[7:0] == OP_NOP);
  assign halt_s = (i_instruction[7:0] == OP_HALT);
  assign rsvd_s = (dst_s inside {INDEX_EN_RSVD_LO, INDEX_EN_RSVD_HI}) ||
                  (src_s inside {INDEX_EN_RSVD_LO, INDEX_EN_RSVD_HI});
  // Skin-to-skin moves would need two bus transfers in one instruction.
  assign clash_s = (src_s inside {INDEX_EN_SKIN_DATA, INDEX_EN_SKIN_IO}) &&
                   (dst_s inside {INDEX_EN_SKIN_FETCH, INDEX_EN_SKIN_DATA, INDEX_EN_SKIN_IO});

  // Assemble the decode record
  always_comb begin
    o_dec         = '0;
    o_dec.dst     = dst_s;
    o_dec.src     = src_s;
    o_dec.nop     = nop_s;
    o_dec.halt    = halt_s;
    o_dec.skin_rd = src_s inside {INDEX_EN_SKIN_DATA, INDEX_EN_SKIN_IO};
    o_dec.skin_wr = dst_s inside {INDEX_EN_SKIN_FETCH, INDEX_EN_SKIN_DATA, INDEX_EN_SKIN_IO};
    o_dec.jump    = (dst_s == INDEX_EN_PC) && (src_s == INDEX_EN_CR);
    o_dec.illegal = !(nop_s || halt_s) &&
                    ((dst_s == src_s) || rsvd_s || (src_s == INDEX_EN_SKIN_FETCH) || clash_s);
  end

endmodule

// File: rtl/bb_control_sequencer.sv
// bb_core instruction sequencer: fetch/decode/execute FSM driving the unit
// enable buses and the skin request/ack handshake with a timeout.
module bb_control_sequencer
  import bb_control_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SKIN_TIMEOUT = 255,
  parameter int TMO_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bb_control_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  decode_t           dec_s, fld_q, fld_d;
  logic              jmp_taken_q, jmp_taken_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [15:0]       ien_q, ien_d;
  logic [15:0]       oen_q, oen_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              halted_q, halted_d;
  logic              stall_fetch_s;
  logic              ack_s;
  logic              tmo_s;

  bb_instr_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .i_instruction (bus.i_instruction),
    .o_dec         (dec_s)
  );

  // Ack counts only against our own registered request, and never while stalled in FETCH.
  assign stall_fetch_s = (state_q == ST_FETCH) && bus.i_stall;
  assign ack_s         = req_q && bus.i_skin_ack && !stall_fetch_s;
  assign tmo_s         = req_q && !ack_s && !stall_fetch_s && (cnt_q == TMO_W'(SKIN_TIMEOUT));

  // Next-state and decode-field capture
  always_comb begin
    state_d     = state_q;
    fld_d       = fld_q;
    jmp_taken_d = jmp_taken_q;
    case (state_q)
      ST_FETCH: begin
        if (ack_s)      state_d = ST_LOAD_IR;
        else if (tmo_s) state_d = ST_HALT;
        else            state_d = ST_FETCH;
      end
      ST_LOAD_IR: state_d = ST_DECODE;
      ST_DECODE: begin
        fld_d       = dec_s;
        jmp_taken_d = bus.i_cond;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        if (fld_q.halt)                             state_d = ST_HALT;
        else if (fld_q.illegal)                     state_d = ST_FETCH;
        else if (fld_q.nop || (fld_q.jump && !jmp_taken_q)) state_d = ST_FETCH;
        else if (fld_q.skin_rd || fld_q.skin_wr)    state_d = ST_SKIN_WAIT;
        else                                        state_d = ST_XFER;
      end
      ST_SKIN_WAIT: begin
        if (ack_s)      state_d = ST_XFER;
        else if (tmo_s) state_d = ST_HALT;
        else            state_d = ST_SKIN_WAIT;
      end
      ST_XFER: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output and timeout-counter next values, computed from the next state so outputs register cleanly
  always_comb begin
    req_d     = ((state_d == ST_FETCH) && !bus.i_stall) || (state_d == ST_SKIN_WAIT);
    we_d      = (state_d == ST_SKIN_WAIT) && fld_d.skin_wr;
    illegal_d = (state_d == ST_EXEC) && fld_d.illegal;
    halted_d  = (state_d == ST_HALT);
    bus_err_d = bus_err_q || tmo_s;
    ien_d     = 16'h0000;
    oen_d     = 16'h0000;
    case (state_d)
      ST_LOAD_IR: begin
        ien_d = unit_onehot(INDEX_EN_IR);
        oen_d = unit_onehot(INDEX_EN_SKIN_FETCH);
      end
      ST_XFER: begin
        ien_d = unit_onehot(fld_d.dst);
        oen_d = unit_onehot(fld_d.src);
      end
      default: begin
        ien_d = 16'h0000;
        oen_d = 16'h0000;
      end
    endcase
    if ((state_d != state_q) || ack_s || stall_fetch_s || !req_q) cnt_d = '0;
    else                                                          cnt_d = cnt_q + TMO_W'(1);
  end

  // State, decode fields, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      fld_q       <= '0;
      jmp_taken_q <= 1'b0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      ien_q       <= 16'h0000;
      oen_q       <= 16'h0000;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fld_q       <= fld_d;
      jmp_taken_q <= jmp_taken_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      ien_q       <= ien_d;
      oen_q       <= oen_d;
      illegal_q   <= illegal_d;
      bus_err_q   <= bus_err_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.o_skin_req  = req_q;
  assign bus.o_skin_we   = we_q;
  assign bus.o_unit_ien  = ien_q;
  assign bus.o_unit_oen  = oen_q;
  assign bus.o_illegal   = illegal_q;
  assign bus.o_bus_error = bus_err_q;
  assign bus.o_halted    = halted_q;

endmodule
